// File: rtl/riscv_regfile_mp_pkg.sv
// Shared types and defaults for the multi-port RV32 integer register file.
package riscv_regfile_mp_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int REG_ADDR_W    = $clog2(NREGS_DEFAULT);

  typedef logic [REG_ADDR_W-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xlen_t;

  // Hard-wired zero register
  localparam reg_addr_t X0 = {REG_ADDR_W{1'b0}};

endpackage

// File: rtl/riscv_regfile_mp_if.sv
// Bus bundle between issue/writeback logic (master) and the register file (slave).
interface riscv_regfile_mp_if
  import riscv_regfile_mp_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic [NWR-1:0]      wr_en_i;
  logic [NWR*AW-1:0]   wr_addr_i;
  logic [NWR*XLEN-1:0] wr_data_i;
  logic                sb_set_en_i;
  logic [AW-1:0]       sb_set_addr_i;
  logic [AW:0]         busy_cnt_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, sb_set_en_i, sb_set_addr_i,
    input  rd_data_o, rd_busy_o, busy_cnt_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, sb_set_en_i, sb_set_addr_i,
    output rd_data_o, rd_busy_o, busy_cnt_o
  );

endinterface

// File: rtl/riscv_regfile_mp_rdport.sv
// One read port: x0 masking, write-forwarding with highest-port priority,
// and an optional output register for the registered-read variant.
module riscv_regfile_rdport
  import riscv_regfile_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int AW       = REG_ADDR_W,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AW-1:0]       addr_i,
  input  logic [XLEN-1:0]     stored_i,
  input  logic                busy_i,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0]     data_o,
  output logic                busy_o
);

  // The registered variant is write-first, so it needs the forwarded value
  // regardless of BYPASS; the combinational variant forwards only if enabled.
  localparam bit USE_FWD = (READ_LAT == 1) || (BYPASS == 1);

  logic            fwd_hit_s;
  logic [XLEN-1:0] fwd_data_s;
  logic            hit_s;
  logic [XLEN-1:0] data_s;
  logic [XLEN-1:0] data_r;
  logic            busy_r;

  // Find the highest-index enabled write that targets this read address
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = {XLEN{1'b0}};
    hit_s      = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      hit_s      = wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr_i);
      fwd_data_s = hit_s ? wr_data_i[j*XLEN +: XLEN] : fwd_data_s;
      fwd_hit_s  = fwd_hit_s | hit_s;
    end
  end

  // Select stored or forwarded data; x0 always reads as zero
  always_comb begin
    if (addr_i == AW'(X0)) begin
      data_s = {XLEN{1'b0}};
    end else if (USE_FWD && fwd_hit_s) begin
      data_s = fwd_data_s;
    end else begin
      data_s = stored_i;
    end
  end

  // Output register used when reads have one cycle of latency
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= {XLEN{1'b0}};
      busy_r <= 1'b0;
    end else begin
      data_r <= data_s;
      busy_r <= busy_i;
    end
  end

  assign data_o = (READ_LAT == 1) ? data_r : data_s;
  assign busy_o = (READ_LAT == 1) ? busy_r : busy_i;

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Holds storage, write-port priority, the busy vector and its population count.
module riscv_regfile_mp
  import riscv_regfile_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input logic               clk,
  input logic               reset,
  riscv_regfile_mp_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]     regs_r [NREGS];
  logic [NREGS-1:0]    busy_r;
  logic [AW:0]         busy_cnt_r;

  logic [NREGS-1:0]    wr_hit_s;
  logic [XLEN-1:0]     wr_val_s [NREGS];
  logic                wr_match_s;
  logic                set_match_s;
  logic [NREGS-1:0]    busy_nxt_s;
  logic [AW:0]         busy_cnt_nxt_s;
  logic [NRD*XLEN-1:0] rd_data_s;
  logic [NRD-1:0]      rd_busy_s;

  // Per register: is it written this cycle and by which data (highest port wins, x0 dropped)
  always_comb begin
    wr_match_s = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      wr_hit_s[r] = 1'b0;
      wr_val_s[r] = {XLEN{1'b0}};
      for (int j = 0; j < NWR; j++) begin
        wr_match_s  = bus.wr_en_i[j] && (bus.wr_addr_i[j*AW +: AW] == AW'(r)) && (r != 0);
        wr_val_s[r] = wr_match_s ? bus.wr_data_i[j*XLEN +: XLEN] : wr_val_s[r];
        wr_hit_s[r] = wr_hit_s[r] | wr_match_s;
      end
    end
  end

  // Next busy vector (issue set beats writeback clear) and its population count
  always_comb begin
    set_match_s    = 1'b0;
    busy_nxt_s     = {NREGS{1'b0}};
    busy_cnt_nxt_s = {(AW+1){1'b0}};
    for (int r = 0; r < NREGS; r++) begin
      set_match_s    = bus.sb_set_en_i && (bus.sb_set_addr_i == AW'(r)) && (r != 0);
      busy_nxt_s[r]  = set_match_s | (busy_r[r] & ~wr_hit_s[r]);
      busy_cnt_nxt_s = busy_cnt_nxt_s + {{AW{1'b0}}, busy_nxt_s[r]};
    end
  end

  // Register storage update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit_s[r]) begin
          regs_r[r] <= wr_val_s[r];
        end
      end
    end
  end

  // Scoreboard state and busy count
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r     <= {NREGS{1'b0}};
      busy_cnt_r <= {(AW+1){1'b0}};
    end else begin
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= busy_cnt_nxt_s;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] addr_s;
      assign addr_s = bus.rd_addr_i[k*AW +: AW];

      riscv_regfile_rdport #(
        .XLEN     (XLEN),
        .AW       (AW),
        .NWR      (NWR),
        .BYPASS   (BYPASS),
        .READ_LAT (READ_LAT)
      ) u_rdport (
        .clk       (clk),
        .reset     (reset),
        .addr_i    (addr_s),
        .stored_i  (regs_r[addr_s]),
        .busy_i    (busy_r[addr_s]),
        .wr_en_i   (bus.wr_en_i),
        .wr_addr_i (bus.wr_addr_i),
        .wr_data_i (bus.wr_data_i),
        .data_o    (rd_data_s[k*XLEN +: XLEN]),
        .busy_o    (rd_busy_s[k])
      );
    end
  endgenerate

  assign bus.rd_data_o  = rd_data_s;
  assign bus.rd_busy_o  = rd_busy_s;
  assign bus.busy_cnt_o = busy_cnt_r;

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Testbench for riscv_regfile_mp: three configurations share one clock/reset.
//   unit 0 (ia/dut_a): NWR=2, BYPASS=1, READ_LAT=0
//   unit 1 (ib/dut_b): NWR=1, BYPASS=0, READ_LAT=0
//   unit 2 (ic/dut_c): NWR=2, READ_LAT=1
module tb_riscv_regfile_mp;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        busy;
    logic [5:0]  cnt;
  } obs_t;

  typedef struct {
    string tag;
    int    unit;
    int    port;
    obs_t  v;
  } exp_t;

  exp_t sb_q[$];

  riscv_regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ia();
  riscv_regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1)) ib();
  riscv_regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ic();

  riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .READ_LAT(0))
    dut_a (.clk(clk), .reset(reset), .bus(ia));
  riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0), .READ_LAT(0))
    dut_b (.clk(clk), .reset(reset), .bus(ib));
  riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .READ_LAT(1))
    dut_c (.clk(clk), .reset(reset), .bus(ic));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stimulus / observation helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    ia.wr_en_i = 2'b00; ia.sb_set_en_i = 1'b0;
    ib.wr_en_i = 1'b0;  ib.sb_set_en_i = 1'b0;
    ic.wr_en_i = 2'b00; ic.sb_set_en_i = 1'b0;
  endtask

  task automatic set_raddr(int u, logic [4:0] a0, logic [4:0] a1);
    case (u)
      0:       ia.rd_addr_i = {a1, a0};
      1:       ib.rd_addr_i = {a1, a0};
      default: ic.rd_addr_i = {a1, a0};
    endcase
  endtask

  task automatic drive_wr(int u, int p, logic [4:0] a, logic [31:0] d);
    case (u)
      0: begin
        ia.wr_en_i[p] = 1'b1; ia.wr_addr_i[p*5 +: 5] = a; ia.wr_data_i[p*32 +: 32] = d;
      end
      1: begin
        ib.wr_en_i[0] = 1'b1; ib.wr_addr_i = a; ib.wr_data_i = d;
      end
      default: begin
        ic.wr_en_i[p] = 1'b1; ic.wr_addr_i[p*5 +: 5] = a; ic.wr_data_i[p*32 +: 32] = d;
      end
    endcase
  endtask

  task automatic drive_set(int u, logic [4:0] a);
    case (u)
      0:       begin ia.sb_set_en_i = 1'b1; ia.sb_set_addr_i = a; end
      1:       begin ib.sb_set_en_i = 1'b1; ib.sb_set_addr_i = a; end
      default: begin ic.sb_set_en_i = 1'b1; ic.sb_set_addr_i = a; end
    endcase
  endtask

  task automatic expect_out(string tag, int u, int p, logic [31:0] d, logic b, logic [5:0] c);
    exp_t e;
    e.tag = tag; e.unit = u; e.port = p;
    e.v.data = d; e.v.busy = b; e.v.cnt = c;
    sb_q.push_back(e);
  endtask

  function automatic obs_t obs(int u, int p);
    obs_t o;
    case (u)
      0:       begin o.data = ia.rd_data_o[p*32 +: 32]; o.busy = ia.rd_busy_o[p]; o.cnt = ia.busy_cnt_o; end
      1:       begin o.data = ib.rd_data_o[p*32 +: 32]; o.busy = ib.rd_busy_o[p]; o.cnt = ib.busy_cnt_o; end
      default: begin o.data = ic.rd_data_o[p*32 +: 32]; o.busy = ic.rd_busy_o[p]; o.cnt = ic.busy_cnt_o; end
    endcase
    return o;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    exp_t e; obs_t got;
    set_raddr(0, 5'd5, 5'd6);
    #1;
    expect_out("rst_init", 0, 0, 32'h0, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    drive_wr(0, 0, 5'd5, 32'hDEADBEEF);
    drive_set(0, 5'd6);
    tick(); clear_inputs(); #1;
    expect_out("pre_rst_x5", 0, 0, 32'hDEADBEEF, 1'b0, 6'd1);
    expect_out("pre_rst_x6", 0, 1, 32'h0, 1'b1, 6'd1);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    // Reset must beat a simultaneous write
    reset = 1'b1;
    drive_wr(0, 0, 5'd5, 32'h12345678);
    tick(); reset = 1'b0; clear_inputs(); #1;
    expect_out("post_rst_x5", 0, 0, 32'h0, 1'b0, 6'd0);
    expect_out("post_rst_x6", 0, 1, 32'h0, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
  endtask

  task automatic test_x0();
    exp_t e; obs_t got;
    drive_set(0, 5'd8);
    tick(); clear_inputs();
    set_raddr(0, 5'd0, 5'd8);
    drive_wr(0, 0, 5'd0, 32'hFFFFFFFF);
    drive_set(0, 5'd0);
    #1;
    expect_out("x0_same_cycle", 0, 0, 32'h0, 1'b0, 6'd1);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    tick(); clear_inputs(); #1;
    expect_out("x0_after", 0, 0, 32'h0, 1'b0, 6'd1);
    expect_out("x8_busy", 0, 1, 32'h0, 1'b1, 6'd1);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    drive_wr(0, 0, 5'd8, 32'h00000088);
    tick(); clear_inputs(); #1;
    expect_out("x8_retire", 0, 1, 32'h00000088, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e; obs_t got;
    set_raddr(0, 5'd7, 5'd0);
    set_raddr(1, 5'd7, 5'd0);
    drive_wr(0, 0, 5'd7, 32'h00001234);
    drive_wr(1, 0, 5'd7, 32'h00001234);
    #1;
    expect_out("byp_on", 0, 0, 32'h00001234, 1'b0, 6'd0);
    expect_out("byp_off_old", 1, 0, 32'h0, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    tick(); clear_inputs(); #1;
    expect_out("byp_on_stored", 0, 0, 32'h00001234, 1'b0, 6'd0);
    expect_out("byp_off_new", 1, 0, 32'h00001234, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    // Forwarded data must not hide the busy bit in the same cycle
    drive_set(0, 5'd10);
    tick(); clear_inputs();
    set_raddr(0, 5'd10, 5'd0);
    drive_wr(0, 0, 5'd10, 32'h0000A5A5);
    #1;
    expect_out("byp_busy_held", 0, 0, 32'h0000A5A5, 1'b1, 6'd1);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    tick(); clear_inputs(); #1;
    expect_out("byp_busy_clr", 0, 0, 32'h0000A5A5, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
  endtask

  task automatic test_collision();
    exp_t e; obs_t got;
    set_raddr(0, 5'd3, 5'd3);
    drive_wr(0, 0, 5'd3, 32'h0000000A);
    drive_wr(0, 1, 5'd3, 32'h0000000B);
    #1;
    expect_out("coll_fwd", 0, 0, 32'h0000000B, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    tick(); clear_inputs(); #1;
    expect_out("coll_p0", 0, 0, 32'h0000000B, 1'b0, 6'd0);
    expect_out("coll_p1", 0, 1, 32'h0000000B, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e; obs_t got;
    set_raddr(0, 5'd9, 5'd0);
    drive_set(0, 5'd9);
    tick(); clear_inputs(); #1;
    expect_out("sb_set", 0, 0, 32'h0, 1'b1, 6'd1);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    drive_wr(0, 0, 5'd9, 32'h00000099);
    drive_set(0, 5'd9);
    tick(); clear_inputs(); #1;
    expect_out("sb_set_wins", 0, 0, 32'h00000099, 1'b1, 6'd1);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    drive_wr(0, 1, 5'd9, 32'h0000009A);
    tick(); clear_inputs(); #1;
    expect_out("sb_clear", 0, 0, 32'h0000009A, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
  endtask

  task automatic test_read_lat();
    exp_t e; obs_t got;
    set_raddr(2, 5'd4, 5'd0);
    drive_wr(2, 0, 5'd4, 32'h00000055);
    tick(); clear_inputs(); #1;
    expect_out("rl_write_first", 2, 0, 32'h00000055, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    // Changing the address must not affect the output until the next edge
    set_raddr(2, 5'd5, 5'd4);
    #1;
    expect_out("rl_hold", 2, 0, 32'h00000055, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    tick(); #1;
    expect_out("rl_x5", 2, 0, 32'h0, 1'b0, 6'd0);
    expect_out("rl_p1_x4", 2, 1, 32'h00000055, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    set_raddr(2, 5'd4, 5'd4);
    drive_wr(2, 0, 5'd4, 32'h00000077);
    drive_wr(2, 1, 5'd4, 32'h00000066);
    tick(); clear_inputs(); #1;
    expect_out("rl_coll", 2, 1, 32'h00000066, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    // Mark every register busy, including an ignored attempt on x0
    set_raddr(2, 5'd1, 5'd0);
    for (int a = 0; a < 32; a++) begin
      drive_set(2, 5'(a));
      tick();
    end
    clear_inputs(); #1;
    expect_out("rl_sweep_cnt", 2, 0, 32'h0, 1'b1, 6'd31);
    expect_out("rl_sweep_x0", 2, 1, 32'h0, 1'b0, 6'd31);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    set_raddr(2, 5'd31, 5'd4);
    tick(); #1;
    expect_out("rl_busy_x31", 2, 0, 32'h0, 1'b1, 6'd31);
    expect_out("rl_busy_x4", 2, 1, 32'h00000066, 1'b1, 6'd31);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
    // Mid-operation reset clears storage, scoreboard and output registers
    reset = 1'b1;
    tick(); reset = 1'b0; #1;
    expect_out("rl_reset_p0", 2, 0, 32'h0, 1'b0, 6'd0);
    expect_out("rl_reset_p1", 2, 1, 32'h0, 1'b0, 6'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); got = obs(e.unit, e.port); n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%08h busy=%0b cnt=%0d, expected data=%08h busy=%0b cnt=%0d", e.tag, got.data, got.busy, got.cnt, e.v.data, e.v.busy, e.v.cnt);
      end
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    ia.rd_addr_i = '0; ia.wr_en_i = '0; ia.wr_addr_i = '0; ia.wr_data_i = '0;
    ia.sb_set_en_i = 1'b0; ia.sb_set_addr_i = '0;
    ib.rd_addr_i = '0; ib.wr_en_i = '0; ib.wr_addr_i = '0; ib.wr_data_i = '0;
    ib.sb_set_en_i = 1'b0; ib.sb_set_addr_i = '0;
    ic.rd_addr_i = '0; ic.wr_en_i = '0; ic.wr_addr_i = '0; ic.wr_data_i = '0;
    ic.sb_set_en_i = 1'b0; ic.sb_set_addr_i = '0;
    tick();
    tick();
    reset = 1'b0;

    test_reset();
    test_x0();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_read_lat();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
